// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Bundle of the branch-decision, stall and instruction-memory
//               request signals around the PC / fetch-request stage.
//               master = fetch unit, slave = surrounding pipeline / memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if;
  logic [1:0]  branch;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        redirect;
  logic        misalign_exc;

  modport master (
    input  branch, branch_valid, branch_target, jump_target, stall, imem_ready,
    output imem_req, imem_addr, pc, fetch_valid, redirect, misalign_exc
  );

  modport slave (
    output branch, branch_valid, branch_target, jump_target, stall, imem_ready,
    input  imem_req, imem_addr, pc, fetch_valid, redirect, misalign_exc
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : Architectural PC register and fetch-request issue. Picks the
//               next PC (sequential / branch / jump), holds the fetch address
//               stable while a request is outstanding, and pulses redirect to
//               flush younger stages.
//               Optional macro PC_MISALIGN_TRAP_EN: a target with bit 1 set
//               redirects to TRAP_VECTOR and pulses misalign_exc; otherwise
//               target[1:0] are simply cleared.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_q, pc_nx;
  logic [31:0] pend_q, pend_nx;
  logic        pend_mis_q, pend_mis_nx;
  logic        fv_q, fv_nx;
  logic        rd_q, rd_nx;
  logic        mis_q, mis_nx;

  logic        taken;
  logic        req;
  logic        accept;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        target_mis;

  // Target selection: JALR bit 0 is always cleared, then alignment handling.
  always_comb begin
    taken      = bus.branch_valid & ((bus.branch == 2'b01) | (bus.branch == 2'b10));
    raw_target = (bus.branch == 2'b10) ? (bus.jump_target & ~32'h1) : bus.branch_target;
`ifdef PC_MISALIGN_TRAP_EN
    target_mis = raw_target[1];
    target     = raw_target[1] ? TRAP_VECTOR : (raw_target & ~32'h1);
`else
    target_mis = 1'b0;
    target     = raw_target & ~32'h3;
`endif
    req        = (state != BOOT);
    accept     = req & bus.imem_ready & ~bus.stall;
  end

  // Next-state / next-PC: redirects only happen on a cycle the memory accepts,
  // so the fetch address never moves under an outstanding request.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc_q;
    pend_nx     = pend_q;
    pend_mis_nx = pend_mis_q;
    fv_nx       = 1'b0;
    rd_nx       = 1'b0;
    mis_nx      = 1'b0;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (taken) begin
          if (bus.imem_ready) begin
            pc_nx  = target;
            rd_nx  = 1'b1;
            mis_nx = target_mis;
          end else begin
            pend_nx     = target;
            pend_mis_nx = target_mis;
            state_nx    = PEND;
          end
        end else if (accept) begin
          pc_nx = pc_q + 32'd4;
          fv_nx = 1'b1;
        end
      end
      PEND: begin
        // A younger EX-stage decision replaces the parked one.
        if (taken) begin
          pend_nx     = target;
          pend_mis_nx = target_mis;
        end
        if (bus.imem_ready) begin
          pc_nx    = taken ? target : pend_q;
          mis_nx   = taken ? target_mis : pend_mis_q;
          rd_nx    = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  // State register with synchronous reset; a reset discards any parked target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 32'h0;
      pend_mis_q <= 1'b0;
      fv_q       <= 1'b0;
      rd_q       <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      pc_q       <= pc_nx;
      pend_q     <= pend_nx;
      pend_mis_q <= pend_mis_nx;
      fv_q       <= fv_nx;
      rd_q       <= rd_nx;
      mis_q      <= mis_nx;
    end
  end

  assign bus.imem_req     = req;
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.fetch_valid  = fv_q;
  assign bus.redirect     = rd_q;
  assign bus.misalign_exc = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Vector-table bench for pc_fetch_unit with an expected-output
//               queue; hand sequence for reset during a parked redirect.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        fv;
    logic        rd;
    logic        mis;
  } exp_t;

  typedef struct {
    logic        bv;
    logic [1:0]  br;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        st;
    logic        rdy;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   applied = 0;
  int   miscompares = 0;
  vec_t vecs[$];
  exp_t sb[$];

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic bv, input logic [1:0] br,
                              input logic [31:0] bt, input logic [31:0] jt,
                              input logic st, input logic rdy,
                              input logic [31:0] epc, input logic ereq,
                              input logic efv, input logic erd, input logic emis);
    vec_t v;
    v.bv = bv; v.br = br; v.bt = bt; v.jt = jt; v.st = st; v.rdy = rdy;
    v.e  = '{pc: epc, req: ereq, fv: efv, rd: erd, mis: emis};
    vecs.push_back(v);
  endfunction

  // Apply one cycle of inputs at the falling edge and queue its expectation.
  task automatic drive(input vec_t v, input logic r);
    @(negedge clk);
    rst               = r;
    bus.branch_valid  = v.bv;
    bus.branch        = v.br;
    bus.branch_target = v.bt;
    bus.jump_target   = v.jt;
    bus.stall         = v.st;
    bus.imem_ready    = v.rdy;
    sb.push_back(v.e);
  endtask

  // Compare outputs just after the rising edge against the oldest expectation.
  task automatic sample(input string name);
    exp_t e, got;
    @(posedge clk);
    #1;
    applied++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e   = sb.pop_front();
      got = '{pc: bus.pc, req: bus.imem_req, fv: bus.fetch_valid,
              rd: bus.redirect, mis: bus.misalign_exc};
      if (got !== e || bus.imem_addr !== e.pc) begin
        miscompares++;
        $display("FAIL %s: got pc=%h addr=%h req=%b fv=%b rd=%b mis=%b, want pc=%h req=%b fv=%b rd=%b mis=%b",
                 name, got.pc, bus.imem_addr, got.req, got.fv, got.rd, got.mis,
                 e.pc, e.req, e.fv, e.rd, e.mis);
      end
    end
  endtask

  task automatic step(input vec_t v, input logic r, input string name);
    drive(v, r);
    sample(name);
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    logic [31:0] mis_pc;
    logic        mis_flag;

`ifdef PC_MISALIGN_TRAP_EN
    mis_pc   = 32'h0000_0100;
    mis_flag = 1'b1;
`else
    mis_pc   = 32'h0000_0040;
    mis_flag = 1'b0;
`endif

    //   bv  br     bt            jt            st rdy  pc            req fv rd mis
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 1, 0, 0, 0); // BOOT -> RUN
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0004, 1, 1, 0, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0008, 1, 1, 0, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_000C, 1, 1, 0, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0010, 1, 1, 0, 0);
    add(1, 2'b01, 32'h40,       32'h0,        0, 1, 32'h0000_0040, 1, 0, 1, 0); // branch
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0044, 1, 1, 0, 0);
    add(1, 2'b11, 32'h200,      32'h300,      0, 1, 32'h0000_0048, 1, 1, 0, 0); // reserved
    add(0, 2'b01, 32'h200,      32'h0,        0, 1, 32'h0000_004C, 1, 1, 0, 0); // not valid
    add(0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h0000_004C, 1, 0, 0, 0); // stall
    add(0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h0000_004C, 1, 0, 0, 0);
    add(0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h0000_004C, 1, 0, 0, 0);
    add(1, 2'b01, 32'h100,      32'h0,        1, 1, 32'h0000_0100, 1, 0, 1, 0); // stall+taken
    add(1, 2'b10, 32'h0,        32'h81,       0, 0, 32'h0000_0100, 1, 0, 0, 0); // park jump
    add(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0100, 1, 0, 0, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0080, 1, 0, 1, 0); // release
    add(1, 2'b10, 32'h0,        32'h81,       0, 0, 32'h0000_0080, 1, 0, 0, 0);
    add(1, 2'b01, 32'h300,      32'h0,        0, 0, 32'h0000_0080, 1, 0, 0, 0); // overwrite
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0300, 1, 0, 1, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0000_0300, 1, 0, 0, 0); // not ready
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0304, 1, 1, 0, 0);
    add(1, 2'b01, 32'h42,       32'h0,        0, 1, mis_pc,        1, 0, 1, mis_flag);
    add(1, 2'b01, 32'hFFFF_FFFC, 32'h0,       0, 1, 32'hFFFF_FFFC, 1, 0, 1, 0);
    add(0, 2'b00, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 1, 1, 0, 0); // wrap

    idle = '{bv: 1'b0, br: 2'b00, bt: 32'h0, jt: 32'h0, st: 1'b0, rdy: 1'b1,
             e: '{pc: 32'h0, req: 1'b0, fv: 1'b0, rd: 1'b0, mis: 1'b0}};

    // Reset held: PC at reset value, no request, no pulses.
    step(idle, 1'b1, "reset0");
    step(idle, 1'b1, "reset1");

    foreach (vecs[i]) step(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset while a redirect is parked: target must be forgotten.
    v = idle;
    v.bv = 1'b1; v.br = 2'b01; v.bt = 32'h500; v.rdy = 1'b0;
    v.e = '{pc: 32'h0, req: 1'b1, fv: 1'b0, rd: 1'b0, mis: 1'b0};
    step(v, 1'b0, "pend_enter");
    step(idle, 1'b1, "pend_reset");
    v = idle;
    v.e = '{pc: 32'h0, req: 1'b1, fv: 1'b0, rd: 1'b0, mis: 1'b0};
    step(v, 1'b0, "pend_boot");
    v.e = '{pc: 32'h4, req: 1'b1, fv: 1'b1, rd: 1'b0, mis: 1'b0};
    step(v, 1'b0, "pend_discarded");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
